// File: rtl/eth_udp_pkg.sv
// Shared types for the UDP receive packet buffer: FSM encodings, packet
// descriptor layout and small length/keep helpers.
package eth_udp_pkg;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_STORE = 2'd1,
        W_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_FETCH  = 2'd1,
        R_STREAM = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [15:0]      start_ptr;
        logic [LEN_W-1:0] len;
    } pkt_desc_t;

    // Number of 32-bit words holding nbytes payload bytes.
    function automatic logic [15:0] words_of(input logic [LEN_W-1:0] nbytes);
        return 16'((32'(nbytes) + 32'd3) >> 2);
    endfunction

    // Byte enables of the final word, first byte in the MSB lane.
    function automatic logic [3:0] keep_of(input logic [1:0] rem);
        logic [3:0] keep;
        case (rem)
            2'd1:    keep = 4'b1000;
            2'd2:    keep = 4'b1100;
            2'd3:    keep = 4'b1110;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/udp_sdp_ram.sv
// Simple dual-port word RAM: one write port, one read port with a
// registered (1-cycle) read.
module udp_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_reg[raddr];
        end
    end

endmodule

// File: rtl/udp_rx_pkt_buf.sv
// Packet buffer behind the UDP receive stage: stores payload words, commits
// whole packets on rec_end and streams committed packets out with keep/last.
module udp_rx_pkt_buf
    import eth_udp_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DESC_W = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rec_data_en,
    input  logic [31:0]       rec_data,
    input  logic              rec_end,
    input  logic [15:0]       rec_data_num,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic [3:0]        m_keep,
    output logic              m_last,
    output logic [15:0]       m_len,
    output logic [DESC_W:0]   pkt_avail,
    output logic [15:0]       drop_cnt
);

    localparam int DESC_DEPTH = 1 << DESC_W;

    // ---------------- shared state ----------------
    logic [ADDR_W-1:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic              ram_full;

    pkt_desc_t         desc_mem [DESC_DEPTH];
    logic [DESC_W-1:0] desc_wr_idx_reg, desc_rd_idx_reg;
    logic [DESC_W:0]   desc_cnt_reg;
    logic              desc_full;

    assign wr_ptr_inc = wr_ptr_reg + ADDR_W'(1);
    assign ram_full   = (wr_ptr_inc == rd_ptr_reg);
    assign desc_full  = desc_cnt_reg[DESC_W];

    // ---------------- write side ----------------
    wr_state_t   wr_state_reg, wr_state_next;
    logic [15:0] wr_cnt_reg, cnt_now, expected;
    logic [15:0] drop_cnt_reg;
    logic        word_wr, overflow, pkt_end, commit, drop_inc, rollback;

    assign expected = words_of(rec_data_num);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_state_reg <= W_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE, W_STORE: begin
                if (pkt_end) begin
                    wr_state_next = W_IDLE;
                end else if (overflow) begin
                    wr_state_next = W_DROP;
                end else if (word_wr) begin
                    wr_state_next = W_STORE;
                end
            end
            W_DROP: begin
                if (rec_end) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        word_wr  = 1'b0;
        overflow = 1'b0;
        pkt_end  = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        rollback = 1'b0;
        cnt_now  = wr_cnt_reg;
        if (wr_state_reg == W_DROP) begin
            drop_inc = rec_end;
        end else begin
            word_wr  = rec_data_en && !ram_full;
            overflow = rec_data_en && ram_full;
            cnt_now  = ((wr_state_reg == W_IDLE) ? 16'd0 : wr_cnt_reg) + 16'(word_wr);
            // A bare rec_end with nothing stored is not a packet at all.
            pkt_end  = rec_end && ((wr_state_reg == W_STORE) || rec_data_en);
            if (pkt_end) begin
                if (!overflow && (cnt_now == expected) && (expected != 16'd0) && !desc_full) begin
                    commit = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                    rollback = 1'b1;
                end
            end else if (overflow) begin
                rollback = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            wr_cnt_reg     <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            if (rollback) begin
                wr_ptr_reg <= commit_ptr_reg;
            end else if (word_wr) begin
                wr_ptr_reg <= wr_ptr_inc;
            end
            if (word_wr) begin
                wr_cnt_reg <= cnt_now;
            end
            if (commit) begin
                commit_ptr_reg <= word_wr ? wr_ptr_inc : wr_ptr_reg;
            end
            if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t         rd_state_reg, rd_state_next;
    pkt_desc_t         head_desc, next_desc, start_desc;
    logic [ADDR_W-1:0] rd_addr_reg, ram_raddr;
    logic [15:0]       fetch_left_reg, emit_left_reg, m_len_reg;
    logic              ram_vld_reg, pf_valid_reg, m_valid_reg;
    logic [31:0]       pf_data_reg, out_data_reg, ram_rdata;
    logic [1:0]        occ;
    logic              pop, last_hs, start_pkt, rd_en;
    logic              unused_desc_bits;

    assign head_desc        = desc_mem[desc_rd_idx_reg];
    assign next_desc        = desc_mem[desc_rd_idx_reg + DESC_W'(1)];
    assign unused_desc_bits = ^start_desc.start_ptr;
    assign pop              = m_valid_reg && m_ready;
    assign last_hs          = pop && (emit_left_reg == 16'd1);
    assign occ              = 2'(ram_vld_reg) + 2'(pf_valid_reg) + 2'(m_valid_reg);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_state_reg <= R_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:   if (start_pkt) rd_state_next = R_FETCH;
            R_FETCH:  rd_state_next = R_STREAM;
            R_STREAM: if (last_hs) rd_state_next = start_pkt ? R_FETCH : R_IDLE;
            default:  rd_state_next = R_IDLE;
        endcase
    end

    // Reads are credit-limited so the output and prefetch registers can
    // always absorb whatever word the RAM returns next cycle.
    always_comb begin
        start_pkt  = 1'b0;
        start_desc = head_desc;
        rd_en      = 1'b0;
        ram_raddr  = rd_addr_reg;
        case (rd_state_reg)
            R_IDLE: begin
                start_pkt = (desc_cnt_reg != '0);
            end
            R_STREAM: begin
                if (last_hs && (desc_cnt_reg > (DESC_W+1)'(1))) begin
                    start_pkt  = 1'b1;
                    start_desc = next_desc;
                end
            end
            default: ;
        endcase
        if (start_pkt) begin
            rd_en     = 1'b1;
            ram_raddr = start_desc.start_ptr[ADDR_W-1:0];
        end else if ((rd_state_reg != R_IDLE) && (fetch_left_reg != 16'd0) &&
                     ((occ - 2'(pop)) < 2'd2)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_ptr_reg     <= '0;
            rd_addr_reg    <= '0;
            fetch_left_reg <= '0;
            emit_left_reg  <= '0;
            m_len_reg      <= '0;
            ram_vld_reg    <= 1'b0;
            pf_valid_reg   <= 1'b0;
            pf_data_reg    <= '0;
            m_valid_reg    <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            ram_vld_reg <= rd_en;
            if (start_pkt) begin
                m_len_reg      <= start_desc.len;
                rd_addr_reg    <= start_desc.start_ptr[ADDR_W-1:0] + ADDR_W'(1);
                fetch_left_reg <= words_of(start_desc.len) - 16'd1;
                emit_left_reg  <= words_of(start_desc.len);
            end else begin
                if (rd_en) begin
                    rd_addr_reg    <= rd_addr_reg + ADDR_W'(1);
                    fetch_left_reg <= fetch_left_reg - 16'd1;
                end
                if (pop) begin
                    emit_left_reg <= emit_left_reg - 16'd1;
                end
            end
            if (last_hs) begin
                rd_ptr_reg <= rd_addr_reg;
            end
            if (!m_valid_reg || pop) begin
                if (pf_valid_reg) begin
                    out_data_reg <= pf_data_reg;
                    m_valid_reg  <= 1'b1;
                    pf_valid_reg <= ram_vld_reg;
                    if (ram_vld_reg) pf_data_reg <= ram_rdata;
                end else if (ram_vld_reg) begin
                    out_data_reg <= ram_rdata;
                    m_valid_reg  <= 1'b1;
                end else begin
                    m_valid_reg <= 1'b0;
                end
            end else if (ram_vld_reg) begin
                pf_data_reg  <= ram_rdata;
                pf_valid_reg <= 1'b1;
            end
        end
    end

    // ---------------- descriptor FIFO ----------------
    always_ff @(posedge sys_clk) begin
        if (commit) begin
            desc_mem[desc_wr_idx_reg] <= '{start_ptr: 16'(commit_ptr_reg), len: rec_data_num};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            desc_wr_idx_reg <= '0;
            desc_rd_idx_reg <= '0;
            desc_cnt_reg    <= '0;
        end else begin
            if (commit)  desc_wr_idx_reg <= desc_wr_idx_reg + DESC_W'(1);
            if (last_hs) desc_rd_idx_reg <= desc_rd_idx_reg + DESC_W'(1);
            case ({commit, last_hs})
                2'b10:   desc_cnt_reg <= desc_cnt_reg + (DESC_W+1)'(1);
                2'b01:   desc_cnt_reg <= desc_cnt_reg - (DESC_W+1)'(1);
                default: ;
            endcase
        end
    end

    udp_sdp_ram #(
        .DATA_W (32),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .we    (word_wr),
        .waddr (wr_ptr_reg),
        .wdata (rec_data),
        .re    (rd_en),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ---------------- outputs ----------------
    assign m_valid   = m_valid_reg;
    assign m_len     = m_len_reg;
    assign m_last    = m_valid_reg && (emit_left_reg == 16'd1);
    assign m_keep    = !m_valid_reg ? 4'b0000 : (m_last ? keep_of(m_len_reg[1:0]) : 4'b1111);
    assign pkt_avail = desc_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign m_data[8*gi +: 8] = m_keep[gi] ? out_data_reg[8*gi +: 8] : 8'h00;
    end

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// Directed bench for udp_rx_pkt_buf: one initial block of steps, each
// comparison an immediate assertion against a hand-computed value.
module tb_udp_rx_pkt_buf;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rec_data_en = 1'b0;
    logic [31:0] rec_data = '0;
    logic        rec_end = 1'b0;
    logic [15:0] rec_data_num = '0;
    logic        m_ready = 1'b0;
    logic        m_valid, m_last;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [15:0] m_len;
    logic [3:0]  pkt_avail;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 sys_clk = ~sys_clk;

    udp_rx_pkt_buf #(.ADDR_W(9), .DESC_W(3)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rec_data_en  (rec_data_en),
        .rec_data     (rec_data),
        .rec_end      (rec_end),
        .rec_data_num (rec_data_num),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .m_last       (m_last),
        .m_len        (m_len),
        .pkt_avail    (pkt_avail),
        .drop_cnt     (drop_cnt)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic is_end, input logic [15:0] num);
        rec_data_en  = 1'b1;
        rec_data     = data;
        rec_end      = is_end;
        rec_data_num = num;
        step();
        rec_data_en  = 1'b0;
        rec_end      = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int nwords, input logic [15:0] nbytes);
        for (int i = 0; i < nwords; i++) begin
            send_word(base + 32'(i), (i == nwords - 1), nbytes);
        end
    endtask

    task automatic recv(input string tag, input logic [31:0] exp_data, input logic [3:0] exp_keep,
                        input logic exp_last, input logic [15:0] exp_len, input int max_wait,
                        input logic stall);
        int w;
        w = 0;
        while (!m_valid && w < 200) begin
            step();
            w++;
        end
        chk({tag, " wait_ok"}, 32'(w <= max_wait), 32'd1);
        if (stall) begin
            m_ready = 1'b0;
            step();
            chk({tag, " stall_valid"}, 32'(m_valid), 32'd1);
            chk({tag, " stall_data"}, m_data, exp_data);
        end
        m_ready = 1'b1;
        chk({tag, " data"}, m_data, exp_data);
        chk({tag, " keep"}, 32'(m_keep), 32'(exp_keep));
        chk({tag, " last"}, 32'(m_last), 32'(exp_last));
        chk({tag, " len"}, 32'(m_len), 32'(exp_len));
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        sys_rst = 1'b0;
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_last", 32'(m_last), 32'd0);
        chk("rst m_keep", 32'(m_keep), 32'd0);
        chk("rst m_data", m_data, 32'd0);
        chk("rst m_len", 32'(m_len), 32'd0);
        chk("rst pkt_avail", 32'(pkt_avail), 32'd0);
        chk("rst drop_cnt", 32'(drop_cnt), 32'd0);

        // 10-byte packet, rec_end with third word, latency of two cycles
        m_ready = 1'b1;
        send_word(32'h01020304, 1'b0, 16'd0);
        send_word(32'h05060708, 1'b0, 16'd0);
        send_word(32'h090A0B0C, 1'b1, 16'd10);
        chk("t1 lat0 valid", 32'(m_valid), 32'd0);
        step();
        chk("t1 lat1 valid", 32'(m_valid), 32'd0);
        step();
        chk("t1 lat2 valid", 32'(m_valid), 32'd1);
        recv("t1 w0", 32'h01020304, 4'b1111, 1'b0, 16'd10, 0, 1'b0);
        recv("t1 w1", 32'h05060708, 4'b1111, 1'b0, 16'd10, 0, 1'b0);
        recv("t1 w2", 32'h090A0000, 4'b1100, 1'b1, 16'd10, 0, 1'b0);
        chk("t1 pkt_avail", 32'(pkt_avail), 32'd0);

        // Three 64-byte packets, stalled consumer on every other word
        m_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            send_pkt(32'hA0000000 | (32'(p) << 8), 16, 16'd64);
        end
        chk("t2 pkt_avail 3", 32'(pkt_avail), 32'd3);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                recv($sformatf("t2 p%0d w%0d", p, i), 32'hA0000000 | (32'(p) << 8) | 32'(i),
                     4'b1111, (i == 15), 16'd64, 100, 1'(i % 2));
            end
            chk($sformatf("t2 pkt_avail after p%0d", p), 32'(pkt_avail), 32'(2 - p));
        end

        // 600-word packet overflows the 511-word capacity, next packet intact
        do_reset();
        m_ready = 1'b1;
        send_pkt(32'h50000000, 600, 16'd2400);
        step();
        step();
        chk("t3 drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t3 pkt_avail", 32'(pkt_avail), 32'd0);
        chk("t3 no output", 32'(m_valid), 32'd0);
        send_word(32'h11223344, 1'b0, 16'd0);
        send_word(32'h55667788, 1'b1, 16'd8);
        recv("t3 w0", 32'h11223344, 4'b1111, 1'b0, 16'd8, 5, 1'b0);
        recv("t3 w1", 32'h55667788, 4'b1111, 1'b1, 16'd8, 0, 1'b0);
        chk("t3 drop_cnt after", 32'(drop_cnt), 32'd1);

        // Length mismatch, then a bare rec_end, then 7-byte and 1-byte packets
        do_reset();
        m_ready = 1'b1;
        send_word(32'hDEAD0001, 1'b0, 16'd12);
        send_word(32'hDEAD0002, 1'b1, 16'd12);
        chk("t4 drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t4 pkt_avail", 32'(pkt_avail), 32'd0);
        rec_end = 1'b1;
        rec_data_num = 16'd4;
        step();
        rec_end = 1'b0;
        chk("t4 bare end drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t4 bare end pkt_avail", 32'(pkt_avail), 32'd0);
        send_word(32'hAABBCCDD, 1'b0, 16'd0);
        send_word(32'hEEFF1122, 1'b1, 16'd7);
        recv("t4 w0", 32'hAABBCCDD, 4'b1111, 1'b0, 16'd7, 5, 1'b0);
        recv("t4 w1", 32'hEEFF1100, 4'b1110, 1'b1, 16'd7, 0, 1'b0);
        send_word(32'h99887766, 1'b1, 16'd1);
        recv("t4 one byte", 32'h99000000, 4'b1000, 1'b1, 16'd1, 5, 1'b0);

        // Nine packets with the consumer blocked: descriptor FIFO holds eight
        do_reset();
        m_ready = 1'b0;
        for (int p = 0; p < 9; p++) begin
            send_word(32'hC0000000 + 32'(p), 1'b1, 16'd4);
        end
        chk("t5 pkt_avail 8", 32'(pkt_avail), 32'd8);
        chk("t5 drop_cnt", 32'(drop_cnt), 32'd1);
        for (int p = 0; p < 8; p++) begin
            recv($sformatf("t5 p%0d", p), 32'hC0000000 + 32'(p), 4'b1111, 1'b1, 16'd4, 5, 1'b0);
        end
        step();
        step();
        step();
        chk("t5 drained valid", 32'(m_valid), 32'd0);
        chk("t5 drained pkt_avail", 32'(pkt_avail), 32'd0);

        // Reset mid-packet discards committed packets and the drop count
        do_reset();
        m_ready = 1'b0;
        send_word(32'hD0000001, 1'b1, 16'd4);
        send_word(32'hD0000002, 1'b1, 16'd3);
        send_word(32'hD0000003, 1'b1, 16'd8);
        send_word(32'hD0000004, 1'b0, 16'd0);
        chk("t6 pre pkt_avail", 32'(pkt_avail), 32'd2);
        chk("t6 pre drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t6 pre valid", 32'(m_valid), 32'd1);
        do_reset();
        chk("t6 m_valid", 32'(m_valid), 32'd0);
        chk("t6 pkt_avail", 32'(pkt_avail), 32'd0);
        chk("t6 drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6 m_last", 32'(m_last), 32'd0);
        chk("t6 m_keep", 32'(m_keep), 32'd0);
        chk("t6 m_len", 32'(m_len), 32'd0);
        step();
        step();
        step();
        chk("t6 still idle", 32'(m_valid), 32'd0);
        send_word(32'h0A0B0C0D, 1'b1, 16'd2);
        recv("t6 fresh", 32'h0A0B0000, 4'b1100, 1'b1, 16'd2, 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/udp_rx_pkt_buf.md
Name: udp_rx_pkt_buf

Overview:
Packet buffer directly downstream of the UDP receive stage.
- Accepts that stage's 32-bit payload words (rec_data_en/rec_data), plus the end pulse and byte count (rec_end/rec_data_num).
- Stores each packet in a word RAM and commits it atomically on rec_end.
- Presents complete packets to the application over a valid/ready stream with last/keep and length.
- Drops whole packets on overflow or length mismatch; never emits a partial packet.

Parameters:
ADDR_W, 9, log2 of data RAM depth in 32-bit words (512 words)
DESC_W, 3, log2 of descriptor FIFO depth (8 packets)

Ports:
sys_clk  in  1  single clock, all logic on rising edge
sys_rst  in  1  synchronous active-high reset
rec_data_en  in  1  payload word strobe
rec_data  in  32  payload word, first byte in [31:24]
rec_end  in  1  end-of-packet pulse; may coincide with the final rec_data_en
rec_data_num  in  16  payload byte count, valid while rec_end=1
m_valid  out  1  output word valid
m_ready  in  1  consumer accept
m_data  out  32  output word, first byte in [31:24], unused low bytes zero
m_keep  out  4  byte enables, [3] = byte in [31:24]
m_last  out  1  final word of packet
m_len  out  16  packet byte count, held stable for the whole packet
pkt_avail  out  DESC_W+1  committed packets not yet fully read
drop_cnt  out  16  dropped-packet count, saturates at 16'hFFFF

Behaviour:
- Reset (sys_rst=1 at a rising edge) clears pointers, descriptor FIFO, and all state.
  - Outputs after reset: m_valid=0, m_last=0, m_keep=0, m_data=0, m_len=0, pkt_avail=0, drop_cnt=0.
  - Reset asserted mid-packet discards everything, including committed packets.
- Write FSM, states W_IDLE, W_STORE, W_DROP:
  - W_IDLE: rec_data_en -> write word at wr_ptr, wr_cnt=1, go W_STORE. If RAM is full, go W_DROP instead.
  - W_STORE: each rec_data_en writes the word and increments wr_ptr and wr_cnt.
    - A word arriving with the RAM full -> W_DROP, wr_ptr rolled back to commit_ptr.
  - rec_end (in W_IDLE/W_STORE; same-cycle word written first):
    - expected = ceil(rec_data_num/4).
    - Commit when wr_cnt == expected, expected != 0, and descriptor FIFO not full: push {start_ptr, rec_data_num}, set commit_ptr = wr_ptr.
    - Otherwise roll back wr_ptr to commit_ptr and increment drop_cnt (saturating).
    - Go W_IDLE.
  - rec_end with no stored word (W_IDLE, no same-cycle rec_data_en) -> silently ignored, no drop counted.
  - W_DROP: ignore words; on rec_end increment drop_cnt and go W_IDLE.
- Full test: (wr_ptr+1) mod depth == rd_ptr. Usable capacity is depth-1 words. Pointers wrap modulo 2^ADDR_W.
- Read FSM, states R_IDLE, R_FETCH, R_STREAM:
  - R_IDLE -> R_FETCH when the descriptor FIFO is non-empty. Latch m_len and word count, issue RAM read (1-cycle synchronous RAM).
  - R_FETCH -> R_STREAM, m_valid=1.
  - A one-word prefetch register sustains one word per cycle while m_ready=1.
  - m_data/m_keep/m_last hold while m_valid && !m_ready.
  - On the last-word handshake: pop descriptor, advance rd_ptr past the packet, pkt_avail--. Then go R_FETCH if another descriptor exists, else R_IDLE.
- Keep and last on the final word: rem = m_len[1:0]. m_keep = 1000/1100/1110/1111 for rem = 1/2/3/0; masked bytes forced to zero. All other words keep=1111. m_last=1 only on the final word.
- Latency: commit to first m_valid = 2 cycles when the reader is idle.
- Commit and final-word pop in the same cycle: pkt_avail unchanged, both take effect.
- Reads never pass commit_ptr. Writes use only space freed by completed reads.

Decomposition:
- Shared package eth_udp_pkg: wr_state_t, rd_state_t enums, and a pkt_desc_t struct {start_ptr, len}.
- One sub-module, udp_sdp_ram: simple dual-port RAM, width 32, depth 2^ADDR_W, 1-cycle read.

Test Plan:
- 10-byte packet (3 words, rec_end with 3rd word), m_ready=1 -> words 1,2 keep=1111; word 3 keep=1100, low 16 bits zero, m_last=1, m_len=10, first m_valid 2 cycles after commit.
- Three back-to-back 64-byte packets, m_ready toggling 1/0 -> 48 words in order, data stable while stalled, pkt_avail steps 3->0.
- 600-word packet into 512-word RAM -> no output, drop_cnt=1; following 8-byte packet delivered intact.
- rec_data_num=12 but 2 words sent -> dropped, drop_cnt=1, pointers restored.
- 9 packets with m_ready=0 -> 8 committed, 9th dropped, pkt_avail=8.
- sys_rst asserted mid-packet with 2 committed packets -> next cycle m_valid=0, pkt_avail=0, drop_cnt=0.
